// File: rtl/digest_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digest_pkg
//  Description : Shared types, default widths and word-offset helper for the
//                digest readout buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package digest_pkg;

    // Readout FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dig_state_e;

    // Default geometry: 12 x 32-bit words
    localparam int c_DEF_DIG_W  = 384;
    localparam int c_DEF_WORD_W = 32;

    // Bit offset of logical word 'word' inside the snapshot. With msw_first
    // set, word 0 is the most significant slice of the digest.
    function automatic int word_lsb(input int word, input int n_words,
                                    input int word_w, input bit msw_first);
        if (msw_first)
            return (n_words - 1 - word) * word_w;
        else
            return word * word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digest_word_sel.sv
`default_nettype none
// ============================================================================
//  Module      : digest_word_sel
//  Description : Combinational selection of one WORD_W slice of the digest
//                snapshot by word address, with an in-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module digest_word_sel
    import digest_pkg::*;
#(
    parameter int DIG_W     = c_DEF_DIG_W,
    parameter int WORD_W    = c_DEF_WORD_W,
    parameter int ADDR_W    = 4,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic [DIG_W-1:0]  snap,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] word,
    output logic              in_range
);

    localparam int c_N_WORDS = DIG_W / WORD_W;

    logic [WORD_W-1:0] w_words [c_N_WORDS];

    // Slice the snapshot into logical words at elaboration time
    generate
        for (genvar gi = 0; gi < c_N_WORDS; gi++) begin : g_words
            localparam int c_LSB = word_lsb(gi, c_N_WORDS, WORD_W, MSW_FIRST);
            assign w_words[gi] = snap[c_LSB +: WORD_W];
        end
    endgenerate

    // Address decode; out-of-range addresses yield zero
    always_comb begin
        word     = '0;
        in_range = ({1'b0, addr} < (ADDR_W+1)'(c_N_WORDS));
        for (int i = 0; i < c_N_WORDS; i++) begin
            if (addr == ADDR_W'(i))
                word = w_words[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/digest_rd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : digest_rd_buf
//  Description : Snapshots the hash digest on hash_done and serves it as
//                WORD_W-bit words with single and auto-incrementing burst
//                reads over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module digest_rd_buf
    import digest_pkg::*;
#(
    parameter int DIG_W     = c_DEF_DIG_W,
    parameter int WORD_W    = c_DEF_WORD_W,
    parameter int ADDR_W    = 4,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hash_done,
    input  logic [DIG_W-1:0]  hash_f,
    input  logic              dig_clr,
    input  logic              rd_req,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              rd_rdy,
    output logic [WORD_W-1:0] rd_d,
    output logic              rd_vld,
    output logic              rd_err,
    output logic              dig_vld,
    output logic              busy
);

    localparam int c_N_WORDS = DIG_W / WORD_W;

    localparam logic [0:0] c_ST_IDLE = ST_IDLE;
    localparam logic [0:0] c_ST_SEND = ST_SEND;

    localparam logic [ADDR_W:0]   c_N_WORDS_R = (ADDR_W+1)'(c_N_WORDS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_N_WORDS - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic [WORD_W-1:0] r_rd_d;
    logic              r_rd_vld;
    logic              r_rd_err;
    logic [DIG_W-1:0]  r_snap;
    logic              r_dig_vld;
    logic              r_cap_pend;

    logic              w_idle;
    logic              w_start;
    logic              w_capture;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W:0]   w_len_ext;
    logic [ADDR_W:0]   w_len_eff;
    logic [WORD_W-1:0] w_word;
    logic              w_in_range;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_start     = w_idle & (rd_req | burst_start);
    assign w_next_addr = (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
    // In IDLE the selector looks at the requested start word, in SEND at the
    // word following the one currently presented.
    assign w_sel_addr  = w_idle ? rd_addr : w_next_addr;

    // Burst length 0 and over-long bursts both mean a full digest
    assign w_len_ext = {1'b0, burst_len};
    assign w_len_eff = ((burst_len == '0) || (w_len_ext > c_N_WORDS_R)) ?
                       c_N_WORDS_R : w_len_ext;

    // Capture only on a quiet IDLE cycle so a burst never sees a mixed
    // snapshot; dig_clr always wins.
    assign w_capture = w_idle & ~w_start & (hash_done | r_cap_pend) & ~dig_clr;

    digest_word_sel #(
        .DIG_W     (DIG_W),
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .MSW_FIRST (MSW_FIRST)
    ) u_word_sel (
        .snap     (r_snap),
        .addr     (w_sel_addr),
        .word     (w_word),
        .in_range (w_in_range)
    );

    // Snapshot register, valid flag and deferred-capture flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= '0;
            r_dig_vld  <= 1'b0;
            r_cap_pend <= 1'b0;
        end else if (dig_clr) begin
            r_snap     <= '0;
            r_dig_vld  <= 1'b0;
            r_cap_pend <= 1'b0;
        end else if (w_capture) begin
            r_snap     <= hash_f;
            r_dig_vld  <= 1'b1;
            r_cap_pend <= 1'b0;
        end else if (hash_done) begin
            r_cap_pend <= 1'b1;
        end
    end

    // Readout FSM: loads words into the output register and walks bursts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_rd_d   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_addr   <= rd_addr;
                        r_rd_d   <= w_in_range ? w_word : '0;
                        r_rd_err <= ~w_in_range;
                        r_rd_vld <= 1'b1;
                        r_state  <= c_ST_SEND;
                        // An error word always terminates the transfer
                        if (burst_start && w_in_range)
                            r_rem <= w_len_eff;
                        else
                            r_rem <= (ADDR_W+1)'(1);
                    end
                end
                c_ST_SEND: begin
                    if (r_rd_vld && rd_rdy) begin
                        if (r_rem == (ADDR_W+1)'(1)) begin
                            r_rd_vld <= 1'b0;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_rd_d   <= w_word;
                            r_rd_err <= 1'b0;
                            r_rem    <= r_rem - (ADDR_W+1)'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_rd_vld <= 1'b0;
                end
            endcase
        end
    end

    assign rd_d    = r_rd_d;
    assign rd_vld  = r_rd_vld;
    assign rd_err  = r_rd_err;
    assign dig_vld = r_dig_vld;
    assign busy    = ~w_idle;

endmodule
`default_nettype wire
